// File: rtl/ring_fx_sequencer.sv
// Frame-rate scene sequencer for the rings effect: debounced scene button,
// auto-advance timer, per-scene phase animation and a blanking fade.
//
// Ports:
//   clk, rst_n   pixel clock, async active-low reset
//   frame_tick   one-cycle pulse at pixel (0,0) of every frame
//   btn_next     raw push-button (async, active high)
//   auto_en      advance scenes after HOLD_FRAMES frames
//   pause        freeze phase and hold count while playing
//   phase        animation offset to the rings datapath
//   direction    0 = outward, 1 = inward
//   gray_scale   grayscale colour select
//   blank        force RGB to black during the fade
//   scene        current scene index
module ring_fx_sequencer #(
  parameter int HOLD_FRAMES = 240,
  parameter int FADE_FRAMES = 8,
  parameter int DEB_CYCLES  = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_next,
  input  logic       auto_en,
  input  logic       pause,
  output logic [7:0] phase,
  output logic       direction,
  output logic       gray_scale,
  output logic       blank,
  output logic [1:0] scene
);

  typedef enum logic {PLAY, FADE} state_t;

  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [9:0] HMAX = 10'(HOLD_FRAMES - 1);
  localparam logic [7:0] FMAX = 8'(FADE_FRAMES - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);

  function automatic logic [7:0] step_of(input logic [1:0] s);
    logic [7:0] r;
    unique case (s)
      2'd0: r = 8'd1;
      2'd1: r = 8'd2;
      2'd2: r = 8'd1;
      2'd3: r = 8'd3;
    endcase
    return r;
  endfunction

  function automatic logic dir_of(input logic [1:0] s);
    return s[0];
  endfunction

  function automatic logic gray_of(input logic [1:0] s);
    return s == 2'd2;
  endfunction

  logic          sync1;
  logic          sync2;
  logic          deb_level;
  logic [DW-1:0] deb_cnt;
  logic          deb_done;
  logic          deb_rise;

  // The level flips on the DEB_CYCLES-th consecutive differing cycle.
  assign deb_done = (sync2 != deb_level) && (deb_cnt == DMAX);
  assign deb_rise = deb_done && sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync1 <= btn_next;
      sync2 <= sync1;
      if (sync2 != deb_level) begin
        if (deb_done) begin
          deb_level <= sync2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  state_t     state, state_d;
  logic [1:0] scene_d;
  logic [7:0] phase_d;
  logic [9:0] hold_cnt, hold_d;
  logic [7:0] fade_cnt, fade_d;
  logic       next_pend, pend_d;
  logic       blank_d;
  logic       dir_d;
  logic       gray_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PLAY;
      scene      <= 2'd0;
      phase      <= 8'd0;
      hold_cnt   <= 10'd0;
      fade_cnt   <= 8'd0;
      next_pend  <= 1'b0;
      blank      <= 1'b0;
      direction  <= 1'b0;
      gray_scale <= 1'b0;
    end else begin
      state      <= state_d;
      scene      <= scene_d;
      phase      <= phase_d;
      hold_cnt   <= hold_d;
      fade_cnt   <= fade_d;
      next_pend  <= pend_d;
      blank      <= blank_d;
      direction  <= dir_d;
      gray_scale <= gray_d;
    end
  end

  always_comb begin
    state_d = state;
    scene_d = scene;
    phase_d = phase;
    hold_d  = hold_cnt;
    fade_d  = fade_cnt;
    pend_d  = next_pend;
    blank_d = blank;
    unique case (state)
      PLAY: begin
        if (deb_rise) pend_d = 1'b1;
        if (frame_tick) begin
          // Entering the fade clears a request that lands on this tick.
          if (next_pend || (auto_en && hold_cnt == HMAX)) begin
            state_d = FADE;
            blank_d = 1'b1;
            fade_d  = 8'd0;
            pend_d  = 1'b0;
          end else if (!pause) begin
            phase_d = phase + step_of(scene);
            if (hold_cnt != HMAX) hold_d = hold_cnt + 10'd1;
          end
        end
      end
      FADE: begin
        if (frame_tick) begin
          if (fade_cnt == FMAX) begin
            state_d = PLAY;
            scene_d = scene + 2'd1;
            phase_d = 8'd0;
            hold_d  = 10'd0;
            blank_d = 1'b0;
          end else begin
            fade_d = fade_cnt + 8'd1;
          end
        end
      end
    endcase
    dir_d  = dir_of(scene_d);
    gray_d = gray_of(scene_d);
  end

endmodule

// File: tb/tb_ring_fx_sequencer.sv
// Self-checking bench for ring_fx_sequencer: directed scenarios plus random
// traffic compared each cycle against a frame-level reference model.
module tb_ring_fx_sequencer;

  localparam int H = 4;
  localparam int F = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_next = 1'b0;
  logic       auto_en = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] phase;
  logic       direction;
  logic       gray_scale;
  logic       blank;
  logic [1:0] scene;

  ring_fx_sequencer #(
    .HOLD_FRAMES(H),
    .FADE_FRAMES(F),
    .DEB_CYCLES (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .btn_next  (btn_next),
    .auto_en   (auto_en),
    .pause     (pause),
    .phase     (phase),
    .direction (direction),
    .gray_scale(gray_scale),
    .blank     (blank),
    .scene     (scene)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int steps[4] = '{1, 2, 1, 3};
  int dirs[4]  = '{0, 1, 0, 1};
  int grays[4] = '{0, 0, 1, 0};

  // Reference model state
  bit m_fade, m_pend, m_blank;
  int m_scene, m_phase, m_hold, m_fcnt;
  bit s1, s2, lvl;
  int run;

  function automatic void m_reset();
    m_fade = 0; m_pend = 0; m_blank = 0;
    m_scene = 0; m_phase = 0; m_hold = 0; m_fcnt = 0;
    s1 = 0; s2 = 0; lvl = 0; run = 0;
  endfunction

  function automatic bit rise_now();
    return (s2 != lvl) && (run == D - 1) && s2;
  endfunction

  function automatic void m_step(bit ft, bit pz, bit ae, bit bt);
    bit rise = 0;
    if (s2 != lvl) begin
      run++;
      if (run == D) begin
        lvl = s2;
        run = 0;
        rise = s2;
      end
    end else begin
      run = 0;
    end
    s2 = s1;
    s1 = bt;
    if (!m_fade) begin
      if (ft && (m_pend || (ae && m_hold == H - 1))) begin
        m_fade = 1; m_blank = 1; m_fcnt = 0; m_pend = 0;
      end else begin
        if (rise) m_pend = 1;
        if (ft && !pz) begin
          m_phase = (m_phase + steps[m_scene]) % 256;
          if (m_hold < H - 1) m_hold++;
        end
      end
    end else if (ft) begin
      if (m_fcnt == F - 1) begin
        m_scene = (m_scene + 1) % 4;
        m_phase = 0; m_hold = 0; m_blank = 0; m_fade = 0;
      end else begin
        m_fcnt++;
      end
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".phase"}, int'(phase), m_phase);
    chk({tag, ".dir"}, int'(direction), dirs[m_scene]);
    chk({tag, ".gray"}, int'(gray_scale), grays[m_scene]);
    chk({tag, ".blank"}, int'(blank), int'(m_blank));
    chk({tag, ".scene"}, int'(scene), m_scene);
  endtask

  task automatic cyc(input bit ft, input bit pz, input bit ae, input bit bt,
                     input string tag);
    frame_tick = ft; pause = pz; auto_en = ae; btn_next = bt;
    @(posedge clk);
    m_step(ft, pz, ae, bt);
    #1;
    frame_tick = 1'b0;
    chk_all(tag);
  endtask

  task automatic press(input string tag);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, tag);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, tag);
  endtask

  task automatic btn_advance(input string tag);
    press(tag);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, tag);
  endtask

  bit bt_r, ae_r;
  int guard;

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    rst_n = 1'b1;

    // Auto-advance through scene 0
    cyc(1, 0, 1, 0, "a1"); chk("a1.phase_c", int'(phase), 1);
    cyc(1, 0, 1, 0, "a2"); chk("a2.phase_c", int'(phase), 2);
    cyc(1, 0, 1, 0, "a3"); chk("a3.phase_c", int'(phase), 3);
    cyc(1, 0, 1, 0, "a4"); chk("a4.phase_c", int'(phase), 3);
    chk("a4.blank_c", int'(blank), 1);
    cyc(1, 0, 1, 0, "a5");
    cyc(1, 0, 1, 0, "a6");
    chk("a6.scene_c", int'(scene), 1);
    chk("a6.phase_c", int'(phase), 0);
    chk("a6.dir_c", int'(direction), 1);
    chk("a6.blank_c", int'(blank), 0);

    // Scene 1 stepping by 2
    cyc(1, 0, 0, 0, "s1"); chk("s1.phase_c", int'(phase), 2);
    cyc(1, 0, 0, 0, "s2"); chk("s2.phase_c", int'(phase), 4);
    cyc(1, 0, 0, 0, "s3"); chk("s3.phase_c", int'(phase), 6);

    // Button to scene 2, then scene 3; walk phase to 254 and wrap
    btn_advance("b12");
    chk("b12.gray_c", int'(gray_scale), 1);
    btn_advance("b23");
    chk("b23.scene_c", int'(scene), 3);
    for (int i = 0; i < 170; i++) cyc(1, 0, 0, 0, "walk");
    chk("walk.phase_c", int'(phase), 254);
    cyc(1, 0, 0, 0, "wrap");
    chk("wrap.phase_c", int'(phase), 1);

    // Short glitch is rejected, long press is accepted
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, "gl");
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, "gl");
    cyc(1, 0, 0, 0, "gl_t");
    chk("glitch.blank_c", int'(blank), 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, "lp");
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, "lp");
    cyc(1, 0, 0, 0, "lp_t");
    chk("press.blank_c", int'(blank), 1);
    cyc(1, 0, 0, 0, "lp_f1");
    cyc(1, 0, 0, 0, "lp_f2");
    chk("press.scene_c", int'(scene), 0);

    // Pause in PLAY freezes; pause in FADE is ignored
    cyc(1, 0, 0, 0, "p0");
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, "pz");
    chk("pause.phase_c", int'(phase), 1);
    press("pz_b");
    cyc(1, 1, 0, 0, "pz_t");
    chk("pause.blank_c", int'(blank), 1);
    cyc(1, 1, 0, 0, "pzf1");
    cyc(1, 1, 0, 0, "pzf2");
    chk("pausefade.scene_c", int'(scene), 1);
    chk("pausefade.blank_c", int'(blank), 0);

    // Debounced edge coinciding with frame_tick
    guard = 0;
    while (!rise_now() && guard < 20) begin
      cyc(0, 0, 0, 1, "co");
      guard++;
    end
    chk("coincide.reached", int'(rise_now()), 1);
    cyc(1, 0, 0, 1, "co_t");
    chk("coincide.blank_c", int'(blank), 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, "co_r");
    cyc(1, 0, 0, 0, "co_n");
    chk("coincide.next_c", int'(blank), 1);
    cyc(1, 0, 0, 0, "co_f1");
    cyc(1, 0, 0, 0, "co_f2");

    // Random traffic
    bt_r = 0; ae_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bt_r = ~bt_r;
      if ($urandom_range(0, 99) == 0) ae_r = ~ae_r;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          ae_r, bt_r, "rnd");
    end

    // Reset during a FADE in scene 2
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, "pre");
    guard = 0;
    while (!(m_scene == 2 && m_fade) && guard < 200) begin
      cyc(1, 0, 1, 0, "to2");
      guard++;
    end
    chk("fade2.reached", int'(blank), 1);
    chk("fade2.scene", int'(scene), 2);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, "post");
    chk("post.phase_c", int'(phase), 1);
    chk("post.blank_c", int'(blank), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
